// File: rtl/axi4_seq_mul_core_if.sv
// Operand/result handshake bundle between the AXI4 slave wrapper and the shift-add multiplier core.
// Operands travel on in_valid/in_ready, the product returns on out_valid/out_ready.
interface axi4_seq_mul_core_if #(
    parameter int SZ = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [SZ-1:0]   a;
    logic [SZ-1:0]   b;
    logic            out_valid;
    logic            out_ready;
    logic [2*SZ-1:0] res;
    logic            busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, res, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, res, busy
    );
endinterface

// File: rtl/axi4_seq_mul_core.sv
// Radix-2 unsigned shift-add multiplier; SZ edges accept-to-out_valid, or msb(b)+2 with MUL_EARLY_TERM_EN.
// Single op in flight: in_ready only in IDLE, product held in DONE until out_ready.
module axi4_seq_mul_core #(
    parameter int SZ = 32
) (
    input logic               clk,
    input logic               rst,
    axi4_seq_mul_core_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [2*SZ-1:0] mcand_q, mcand_d;
    logic [2*SZ-1:0] acc_q, acc_d;
    logic [2*SZ-1:0] res_q, res_d;
    logic [2*SZ-1:0] acc_sum;
    logic [SZ-1:0]   mplr_q, mplr_d;
    logic            out_valid_q, out_valid_d;

`ifndef MUL_EARLY_TERM_EN
    localparam int CW = (SZ > 1) ? $clog2(SZ) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SZ - 1);
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            acc_q       <= '0;
            res_q       <= '0;
            mplr_q      <= '0;
            out_valid_q <= 1'b0;
`ifndef MUL_EARLY_TERM_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            acc_q       <= acc_d;
            res_q       <= res_d;
            mplr_q      <= mplr_d;
            out_valid_q <= out_valid_d;
`ifndef MUL_EARLY_TERM_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        acc_d       = acc_q;
        res_d       = res_q;
        mplr_d      = mplr_q;
        out_valid_d = out_valid_q;
`ifndef MUL_EARLY_TERM_EN
        cnt_d       = cnt_q;
`endif
        acc_sum     = mplr_q[0] ? (acc_q + mcand_q) : acc_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    mcand_d = {{SZ{1'b0}}, bus.a};
                    mplr_d  = bus.b;
                    acc_d   = '0;
`ifndef MUL_EARLY_TERM_EN
                    cnt_d   = '0;
`endif
                    state_d = CALC;
                end
            end
            CALC: begin
`ifdef MUL_EARLY_TERM_EN
                // Once the remaining multiplier bits are all zero, acc already holds the product.
                if (mplr_q == '0) begin
                    res_d       = acc_q;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    acc_d   = acc_sum;
                    mcand_d = mcand_q << 1;
                    mplr_d  = mplr_q >> 1;
                end
`else
                acc_d   = acc_sum;
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    res_d       = acc_sum;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
`endif
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.res       = res_q;
endmodule

// File: tb/tb_axi4_seq_mul_core.sv
// Bench for axi4_seq_mul_core: directed operand vectors, queue scoreboard with a decoupled output monitor.
// Expected latency follows MUL_EARLY_TERM_EN when the bench is built with it.
module tb_axi4_seq_mul_core;
    typedef struct {
        logic [63:0] res;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
    } vec_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   failures;
    exp_t sb[$];
    logic prev_vld;

    axi4_seq_mul_core_if #(.SZ(32)) bus ();

    axi4_seq_mul_core #(.SZ(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic int exp_lat(input logic [31:0] b);
`ifdef MUL_EARLY_TERM_EN
        int m;
        m = -1;
        for (int i = 0; i < 32; i++)
            if (b[i]) m = i;
        return m + 2;
`else
        return 32;
`endif
    endfunction

    // Monitor: latency checked when out_valid rises, product checked on the handshake.
    always @(negedge clk) begin
        if (rst) begin
            prev_vld = 1'b0;
        end else begin
            if (bus.out_valid && !prev_vld) begin
                if (sb.size() == 0) chk("unexpected_out_valid", 64'd1, 64'd0);
                else                chk("latency_cycle", 64'(cyc), 64'(sb[0].cyc));
            end
            if (bus.out_valid && bus.out_ready && sb.size() > 0) begin
                chk("product", bus.res, sb[0].res);
                void'(sb.pop_front());
            end
            prev_vld = bus.out_valid;
        end
    end

    // Called at posedge+1; returns with the DUT one step past its accept edge.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] p, output int k);
        int   n;
        logic got;
        exp_t e;
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        n   = 0;
        got = 1'b0;
        do begin
            @(negedge clk);
            got = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!got && n < 200);
        k = cyc;
        if (!got) begin
            chk("accept_timeout", 64'd0, 64'd1);
        end else begin
            e.res = p;
            e.cyc = k + exp_lat(b);
            sb.push_back(e);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            chk("completion_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    initial begin
        vec_t vecs[6];
        int   k;
        int   k2;
        int   n;

        checks = 0;
        failures = 0;
        cyc = 0;
        prev_vld = 1'b0;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;

        vecs[0] = '{32'd12551,      32'd41245,      64'd517665995};
        vecs[1] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   64'hFFFFFFFE00000001};
        vecs[2] = '{32'd7,          32'd0,          64'd0};
        vecs[3] = '{32'd7,          32'd1,          64'd7};
        vecs[4] = '{32'd3,          32'd5,          64'd15};
        vecs[5] = '{32'h0000FFFF,   32'h00010000,   64'h00000000FFFF0000};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_res",       bus.res,       64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_busy",      64'(bus.busy), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_in_ready", 64'(bus.in_ready), 64'd1);

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].p, k);
            wait_done();
        end

        // Input churn during CALC must not disturb the latched operands.
        run_op(32'd1000, 32'd1000, 64'd1000000, k);
        bus.a = 32'hDEADBEEF;
        bus.b = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("churn_busy", 64'(bus.busy), 64'd1);
        wait_done();

        // Backpressure: hold the finished product for 5 cycles.
        bus.out_ready = 1'b0;
        run_op(32'h80000000, 32'd2, 64'h0000000100000000, k);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("bp_out_valid_seen", 64'(bus.out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_res_stable", bus.res, 64'h0000000100000000);
            chk("bp_in_ready",  64'(bus.in_ready), 64'd0);
            chk("bp_busy",      64'(bus.busy), 64'd1);
        end
        bus.out_ready = 1'b1;
        bus.a = 32'd3;
        bus.b = 32'd5;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        k = cyc;
        chk("release_in_ready",  64'(bus.in_ready), 64'd1);
        chk("release_out_valid", 64'(bus.out_valid), 64'd0);
        chk("release_busy",      64'(bus.busy), 64'd0);
        chk("release_res_kept",  bus.res, 64'h0000000100000000);
        run_op(32'd3, 32'd5, 64'd15, k2);
        chk("b2b_accept_cycle", 64'(k2), 64'(k + 1));
        wait_done();

        // Asynchronous reset between edges in the middle of CALC.
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, k);
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        chk("arst_res",       bus.res, 64'd0);
        chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_busy",      64'(bus.busy), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
        run_op(32'd123, 32'd456, 64'd56088, k);
        wait_done();

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
